fir_seq_ctrl: RTL and testbench

Sequencing controller for the lab FIR filter. Captures one 8-bit sample per `go` strobe into a circular sample buffer, then time-multiplexes a single multiply-accumulate unit over `TAPS` coefficient taps. It presents the saturated 16-bit result on `y` with a one-cycle `valid` pulse. It sits between the sample source and the `y` consumer, and owns the runtime-loadable coefficient bank.

---
 rtl/fir_pkg.sv | 24 ++
 rtl/fir_mac.sv | 32 +++
 rtl/fir_seq_ctrl.sv | 107 ++++++++++
 tb/tb_fir_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR sequencing controller.
// Holds the FSM encoding, width defaults, power-on coefficients and saturation helper.
package fir_pkg;

  localparam int W_IN_DEF  = 8;
  localparam int W_OUT_DEF = 16;
  localparam int TAPS_MAX  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // All-ones taps make the filter a moving sum after reset.
  localparam logic [W_IN_DEF-1:0] COEF_INIT [TAPS_MAX] = '{default: 8'd1};

  function automatic logic [31:0] sat(input logic [31:0] v, input int w);
    logic [31:0] lim;
    lim = (32'd1 << w) - 32'd1;
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Single unsigned multiply-accumulate unit used once per tap.
// sum is the combinational acc+product so the last tap can be saturated on the same edge.
module fir_mac #(
  parameter int W_IN  = 8,
  parameter int W_ACC = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [W_IN-1:0]  a,
  input  logic [W_IN-1:0]  b,
  output logic [W_ACC-1:0] acc,
  output logic [W_ACC-1:0] sum
);

  logic [2*W_IN-1:0] prod;

  assign prod = {{W_IN{1'b0}}, a} * {{W_IN{1'b0}}, b};
  assign sum  = acc + W_ACC'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR sequencer: captures a sample per go, walks TAPS taps through one MAC,
// then presents the saturated result on y with a single-cycle valid.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int TAPS  = 4,
  parameter int W_IN  = W_IN_DEF,
  parameter int W_OUT = W_OUT_DEF,
  localparam int PW    = $clog2(TAPS),
  localparam int W_ACC = W_OUT + $clog2(TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_IN-1:0]  in,
  input  logic             go,
  input  logic             coef_we,
  input  logic [PW-1:0]    coef_addr,
  input  logic [W_IN-1:0]  coef_data,
  output logic             busy,
  output logic [W_OUT-1:0] y,
  output logic             valid,
  output logic             drop
);

  localparam logic [PW-1:0] LAST = PW'(TAPS - 1);

  state_t            state;
  logic [W_IN-1:0]   samples [TAPS];
  logic [W_IN-1:0]   coefs   [TAPS];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     idx;
  logic [PW-1:0]     rd_ptr;
  logic [W_ACC-1:0]  mac_acc;
  logic [W_ACC-1:0]  mac_sum;
  logic [31:0]       sat_val;

  // Newest sample pairs with tap 0; older samples walk backwards around the ring.
  always_comb begin
    if (wr_ptr >= idx) rd_ptr = wr_ptr - idx;
    else               rd_ptr = PW'(TAPS) + wr_ptr - idx;
  end

  always_comb begin
    sat_val = sat(32'(mac_sum), W_OUT);
  end

  fir_mac #(
    .W_IN  (W_IN),
    .W_ACC (W_ACC)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (state == ST_IDLE && go),
    .en  (state == ST_MAC),
    .a   (samples[rd_ptr]),
    .b   (coefs[idx]),
    .acc (mac_acc),
    .sum (mac_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      y      <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      drop   <= 1'b0;
      wr_ptr <= '0;
      idx    <= '0;
      for (int i = 0; i < TAPS; i++) begin
        samples[i] <= '0;
        coefs[i]   <= W_IN'(COEF_INIT[i]);
      end
    end else begin
      valid <= 1'b0;
      drop  <= go && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (coef_we) coefs[coef_addr] <= coef_data;
          if (go) begin
            samples[wr_ptr] <= in;
            idx             <= '0;
            busy            <= 1'b1;
            state           <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (idx == LAST) begin
            y     <= sat_val[W_OUT-1:0];
            valid <= 1'b1;
            idx   <= '0;
            state <= ST_OUT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_OUT: begin
          wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl with TAPS=4: expected results are queued at
// stimulus time and checked by a monitor whenever valid is seen.
module tb_fir_seq_ctrl;
  import fir_pkg::*;

  localparam int TAPS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic        coef_we = 1'b0;
  logic [7:0]  in = '0;
  logic [7:0]  coef_data = '0;
  logic [1:0]  coef_addr = '0;
  logic        busy, valid, drop;
  logic [15:0] y;

  int pass_cnt = 0;
  int check_cnt = 0;
  int cyc = 0;
  int drop_cnt = 0;
  logic prev_valid = 1'b0;
  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];

  fir_seq_ctrl #(.TAPS(TAPS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .go        (go),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .busy      (busy),
    .y         (y),
    .valid     (valid),
    .drop      (drop)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (drop) drop_cnt++;
    if (valid) begin
      check("valid_one_cycle", int'(prev_valid), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", int'(y), -1);
      end else begin
        check("y", int'(y), int'(exp_q.pop_front()));
        check("latency", cyc, exp_cyc_q.pop_front());
      end
    end
    prev_valid = valid;
  end

  // driver tasks
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic send(input logic [7:0] s, input logic [15:0] e, input bit expect_out);
    wait_idle();
    in = s;
    go = 1'b1;
    @(posedge clk); #1;
    if (expect_out) begin
      exp_q.push_back(e);
      exp_cyc_q.push_back(cyc + TAPS);
    end
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic write_coef(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    coef_we = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic do_reset();
    drain();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int d0;
    repeat (2) @(negedge clk);
    check("reset_y", int'(y), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_drop", int'(drop), 0);
    rst = 1'b0;

    // moving sum with default coefficients; 10 ages out on the fifth sample
    send(8'd10, 16'd10, 1'b1);
    send(8'd20, 16'd30, 1'b1);
    send(8'd30, 16'd60, 1'b1);
    send(8'd40, 16'd100, 1'b1);
    send(8'd50, 16'd140, 1'b1);

    // impulse response reveals tap ordering
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(2'(i), 8'(i + 1));
    send(8'd1, 16'd1, 1'b1);
    send(8'd0, 16'd2, 1'b1);
    send(8'd0, 16'd3, 1'b1);
    send(8'd0, 16'd4, 1'b1);

    // saturation
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(2'(i), 8'd255);
    send(8'd255, 16'd65025, 1'b1);
    send(8'd255, 16'hFFFF, 1'b1);
    send(8'd255, 16'hFFFF, 1'b1);
    send(8'd255, 16'hFFFF, 1'b1);

    // reset in the middle of MAC discards the result and restores defaults
    drain();
    wait_idle();
    in = 8'd99;
    go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midmac_rst_y", int'(y), 0);
    check("midmac_rst_busy", int'(busy), 0);
    check("midmac_rst_valid", int'(valid), 0);
    @(negedge clk);
    rst = 1'b0;
    send(8'd7, 16'd7, 1'b1);

    // go and coef_we during MAC are ignored
    do_reset();
    wait_idle();
    in = 8'd5;
    go = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(16'd5);
    exp_cyc_q.push_back(cyc + TAPS);
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    go = 1'b1;
    in = 8'd200;
    coef_we = 1'b1;
    coef_addr = 2'd0;
    coef_data = 8'd9;
    @(negedge clk);
    check("drop_pulse", int'(drop), 1);
    go = 1'b0;
    coef_we = 1'b0;
    @(negedge clk);
    check("drop_clear", int'(drop), 0);
    send(8'd6, 16'd11, 1'b1);

    // go and coef_we together in IDLE: new coefficient used immediately
    wait_idle();
    coef_we = 1'b1;
    coef_addr = 2'd0;
    coef_data = 8'd3;
    in = 8'd4;
    go = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(16'd23);
    exp_cyc_q.push_back(cyc + TAPS);
    @(negedge clk);
    go = 1'b0;
    coef_we = 1'b0;

    // go held high: one acceptance every TAPS+2 cycles, drops in between
    do_reset();
    d0 = drop_cnt;
    wait_idle();
    in = 8'd3;
    go = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    exp_q.push_back(16'd3);
    exp_cyc_q.push_back(k + TAPS);
    exp_q.push_back(16'd6);
    exp_cyc_q.push_back(k + TAPS + 6);
    exp_q.push_back(16'd9);
    exp_cyc_q.push_back(k + TAPS + 12);
    repeat (12) @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    drain();
    check("b2b_drops", drop_cnt - d0, 10);

    drain();
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
